restoring_unsigned_divider_16: RTL and testbench
================================================

RESTORING_UNSIGNED_DIVIDER_16 -- requirements
Module: restoring_unsigned_divider_16

Interface
REQ-001 SHALL have parameter none; width fixed at 32-bit dividend, 16-bit divisor (inverse of the 16x16 unsigned multiplier).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request; operands sampled on the cycle start=1 is accepted.
REQ-005 dividend  input  32  unsigned dividend (multiplier product width).
REQ-006 divisor  input  16  unsigned divisor.
REQ-007 busy  output  1  high while iterating.
REQ-008 done  output  1  one-cycle pulse, results valid.
REQ-009 quotient  output  16  unsigned quotient.
REQ-010 remainder  output  16  unsigned remainder.
REQ-011 ovf  output  1  quotient does not fit in 16 bits (includes divisor=0); present only per REQ-030.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; reset state IDLE.
REQ-013 start accepted only in IDLE or DONE; start in RUN ignored, operands unchanged.
REQ-014 On acceptance at cycle T: latch dividend/divisor, 17-bit partial remainder = {0, dividend[31:16]}, iteration counter = 0, go to RUN.
REQ-015 RUN: one restoring step per cycle -- shift partial remainder left bringing in next dividend bit MSB-first, trial-subtract divisor, keep difference and shift in quotient bit 1 if non-negative, else restore and shift in 0.
REQ-016 Exactly 16 RUN cycles (T+1..T+16); counter 0..15, exits RUN when counter=15.
REQ-017 busy=1 exactly in cycles T+1..T+16.
REQ-018 done=1 exactly in cycle T+17 (DONE state), 0 otherwise; DONE returns to IDLE next cycle unless start=1.
REQ-019 quotient/remainder valid from T+17, held stable until the next accepted start; not updated during RUN (internal shadow registers only).
REQ-020 For non-overflow operands: dividend = quotient*divisor + remainder, remainder < divisor, exactly.
REQ-021 start=1 in DONE: accepted, done pulses that cycle, RUN begins next cycle (back-to-back throughput 17 cycles/op).
REQ-022 Operand input changes after acceptance SHALL NOT affect the running operation.

Reset
REQ-023 rst=1 at any edge forces IDLE regardless of state, including mid-RUN; in-flight operation discarded, no done pulse.
REQ-024 Reset values: busy=0, done=0, quotient=16'h0000, remainder=16'h0000, ovf=0, counter=0.
REQ-025 rst has priority over start in the same cycle.
REQ-026 First start may be accepted the cycle after rst deasserts.

Configuration
REQ-030 Macro DIV_OVF_CHECK_EN: defined -> on acceptance compare dividend[31:16] >= divisor; if true, skip RUN, go directly to DONE at T+1 with done=1, ovf=1, quotient=16'hFFFF, remainder=16'h0000; busy stays 0.
REQ-031 DIV_OVF_CHECK_EN undefined -> ovf port present but tied 0, every operation takes 16 RUN cycles; quotient/remainder for overflow operands are not defined by this spec and SHALL NOT be checked.
REQ-032 ovf, when enabled, held with quotient/remainder until next accepted start; cleared to 0 on a non-overflow completion.

Verification
REQ-040 dividend=32'h025F7D77, divisor=16'h0F67, start at T -> busy T+1..T+16, done at T+17, quotient=16'h2771, remainder=16'h0000, ovf=0.
REQ-041 dividend=32'h025F7D80, divisor=16'h0F67 -> quotient=16'h2771, remainder=16'h0009.
REQ-042 dividend=32'hFFFE0001, divisor=16'hFFFF -> quotient=16'hFFFF, remainder=16'h0000, ovf=0 (boundary max).
REQ-043 With DIV_OVF_CHECK_EN: divisor=16'h0000 (any dividend) and dividend=32'h00010000/divisor=16'h0001 -> done at T+1, ovf=1, quotient=16'hFFFF, remainder=0, busy never 1.
REQ-044 rst pulsed at T+8 of an operation -> no done pulse, outputs at reset values next cycle; new start accepted after completes correctly; start pulsed at T+5 ignored.
REQ-045 Back-to-back: start held in DONE cycle with new operands -> second done exactly 17 cycles after the first, both results correct.

Source files
------------

// File: rtl/restoring_unsigned_divider_16.sv
// Sequential restoring divider: 32-bit dividend / 16-bit divisor, one quotient bit per cycle.
// Optional macro DIV_OVF_CHECK_EN enables early overflow detection (quotient wider than 16 bits).
module restoring_unsigned_divider_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [15:0] divisor_q, divisor_d;
  logic [15:0] low_q, low_d;
  logic [16:0] prem_q, prem_d;
  logic [15:0] qshadow_q, qshadow_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic [15:0] quotient_q, quotient_d;
  logic [15:0] remainder_q, remainder_d;

  logic        accept;
  logic        ovf_detect;
  logic [17:0] shifted;
  logic [16:0] trial;
  logic        q_bit;
  logic [16:0] step_prem;
  logic [15:0] step_quot;

  always_comb begin
    accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
`ifdef DIV_OVF_CHECK_EN
    ovf_detect = (dividend[31:16] >= divisor);
`else
    ovf_detect = 1'b0;
`endif

    // Restoring step: shift in next dividend bit, keep the difference only if it is non-negative
    shifted   = {prem_q, low_q[15]};
    trial     = shifted[16:0] - {1'b0, divisor_q};
    q_bit     = (shifted >= {2'b00, divisor_q});
    step_prem = q_bit ? trial : shifted[16:0];
    step_quot = {qshadow_q[14:0], q_bit};
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    divisor_d   = divisor_q;
    low_d       = low_q;
    prem_d      = prem_q;
    qshadow_d   = qshadow_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          divisor_d = divisor;
          low_d     = dividend[15:0];
          prem_d    = {1'b0, dividend[31:16]};
          qshadow_d = 16'h0000;
          count_d   = 4'd0;
          if (ovf_detect) begin
            state_d     = S_DONE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            ovf_d       = 1'b1;
            quotient_d  = 16'hFFFF;
            remainder_d = 16'h0000;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
          end
        end
      end

      S_RUN: begin
        prem_d    = step_prem;
        qshadow_d = step_quot;
        low_d     = {low_q[14:0], 1'b0};
        count_d   = count_q + 4'd1;
        // Visible results only change on the final step; the shadows carry the work
        if (count_q == 4'd15) begin
          state_d     = S_DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          ovf_d       = 1'b0;
          count_d     = 4'd0;
          quotient_d  = step_quot;
          remainder_d = step_prem[15:0];
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= 4'd0;
      divisor_q   <= 16'h0000;
      low_q       <= 16'h0000;
      prem_q      <= 17'h00000;
      qshadow_q   <= 16'h0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      quotient_q  <= 16'h0000;
      remainder_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      divisor_q   <= divisor_d;
      low_q       <= low_d;
      prem_q      <= prem_d;
      qshadow_q   <= qshadow_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_restoring_unsigned_divider_16.sv
// Directed bench for restoring_unsigned_divider_16: scoreboard of expected results popped at each done.
// Overflow checks follow DIV_OVF_CHECK_EN when it is defined.
module tb_restoring_unsigned_divider_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        ovf;

  restoring_unsigned_divider_16 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] dvd;
    logic [15:0] dvs;
    logic [15:0] q;
    logic [15:0] r;
    bit          check_qr;
    logic        exp_ovf;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] held_q = 16'h0000;
  logic [15:0] held_r = 16'h0000;
  bit          held_valid = 1'b1;
  int          n_assert = 0;
  int          n_fail = 0;
  int          done_cyc = 0;
  int          first_done_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a start request and record what the result must be
  task automatic push_start(input logic [31:0] dvd, input logic [15:0] dvs);
    exp_t e;
    e.dvd = dvd;
    e.dvs = dvs;
    e.check_qr = 1'b1;
    e.exp_ovf = 1'b0;
    if (dvs == 16'h0000 || dvd[31:16] >= dvs) begin
`ifdef DIV_OVF_CHECK_EN
      e.q = 16'hFFFF;
      e.r = 16'h0000;
      e.exp_ovf = 1'b1;
`else
      e.check_qr = 1'b0;
      e.q = 16'h0000;
      e.r = 16'h0000;
`endif
    end else begin
      e.q = 16'(dvd / {16'h0000, dvs});
      e.r = 16'(dvd % {16'h0000, dvs});
    end
    start = 1'b1;
    dividend = dvd;
    divisor = dvs;
    sb.push_back(e);
  endtask

  // Complete the acceptance cycle T; returns in cycle T+1 with operands scrambled
  task automatic accept_cycle();
    @(negedge clk);
    start = 1'b0;
    dividend = $urandom;
    divisor = 16'($urandom);
  endtask

  // Cycles T+1..T+16: busy high, done low, previous results held; optional start pulse ignored
  task automatic run_phase(input string tag, input int inject_at);
    for (int k = 1; k <= 16; k++) begin
      if (k == inject_at + 1) start = 1'b0;
      check({tag, "_busy_run"}, 32'(busy), 32'd1);
      check({tag, "_done_run"}, 32'(done), 32'd0);
      if (k == 16 && held_valid) begin
        check({tag, "_q_held_run"}, 32'(quotient), 32'(held_q));
        check({tag, "_r_held_run"}, 32'(remainder), 32'(held_r));
      end
      if (k == inject_at) begin
        start = 1'b1;
        dividend = 32'h12345678;
        divisor = 16'h0003;
      end
      @(negedge clk);
    end
  endtask

  // Done cycle: pop scoreboard and compare; optionally chain a new start in this same cycle
  task automatic finish_op(input string tag, input bit chain, input logic [31:0] ndvd, input logic [15:0] ndvs);
    exp_t e;
    done_cyc = cyc;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check({tag, "_sb_entry"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.check_qr) begin
        check({tag, "_quotient"}, 32'(quotient), 32'(e.q));
        check({tag, "_remainder"}, 32'(remainder), 32'(e.r));
      end
      check({tag, "_ovf"}, 32'(ovf), 32'(e.exp_ovf));
      held_valid = e.check_qr;
      held_q = e.q;
      held_r = e.r;
    end
    if (chain) begin
      push_start(ndvd, ndvs);
      accept_cycle();
    end else begin
      @(negedge clk);
      check({tag, "_done_pulse_end"}, 32'(done), 32'd0);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
      if (held_valid) check({tag, "_q_held_idle"}, 32'(quotient), 32'(held_q));
    end
  endtask

  task automatic full_op(input string tag, input logic [31:0] dvd, input logic [15:0] dvs, input int inject_at);
    push_start(dvd, dvs);
    accept_cycle();
    run_phase(tag, inject_at);
    finish_op(tag, 1'b0, 32'h0, 16'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] rdvs;
    logic [31:0] rdvd;

    rst = 1'b1;
    start = 1'b0;
    dividend = 32'h0;
    divisor = 16'h0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_quotient", 32'(quotient), 32'd0);
    check("reset_remainder", 32'(remainder), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);

    // Reset wins over a simultaneous start
    start = 1'b1;
    dividend = 32'h00000064;
    divisor = 16'h0005;
    @(negedge clk);
    check("rst_prio_busy", 32'(busy), 32'd0);
    check("rst_prio_done", 32'(done), 32'd0);

    // First start accepted in the first cycle after reset release
    rst = 1'b0;
    full_op("req040", 32'h025F7D77, 16'h0F67, 0);
    full_op("req041_ign_start", 32'h025F7D80, 16'h0F67, 5);
    full_op("req042_max", 32'hFFFE0001, 16'hFFFF, 0);

    // Back-to-back: second start held during the first done cycle
    push_start(32'h12345678, 16'hABCD);
    accept_cycle();
    run_phase("b2b_a", 0);
    first_done_cyc = cyc;
    finish_op("b2b_a", 1'b1, 32'h7FFF0000, 16'h8000);
    first_done_cyc = done_cyc;
    run_phase("b2b_b", 0);
    finish_op("b2b_b", 1'b0, 32'h0, 16'h0);
    check("b2b_spacing", 32'(done_cyc - first_done_cyc), 32'd17);

    // Reset in cycle T+8 discards the operation
    push_start(32'h00FF1234, 16'h1111);
    accept_cycle();
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    held_valid = 1'b1;
    held_q = 16'h0000;
    held_r = 16'h0000;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_quotient", 32'(quotient), 32'd0);
    check("midrst_remainder", 32'(remainder), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done), 32'd0);
    end
    full_op("after_rst", 32'h0BADF00D, 16'hCAFE, 0);

`ifdef DIV_OVF_CHECK_EN
    push_start(32'h12345678, 16'h0000);
    accept_cycle();
    finish_op("ovf_div0", 1'b0, 32'h0, 16'h0);
    push_start(32'h00010000, 16'h0001);
    accept_cycle();
    finish_op("ovf_edge", 1'b0, 32'h0, 16'h0);
    full_op("ovf_clear", 32'h00000064, 16'h0005, 0);
`else
    full_op("div0_noovf", 32'hDEADBEEF, 16'h0000, 0);
    full_op("post_div0", 32'h00000064, 16'h0005, 0);
`endif

    for (int i = 0; i < 4; i++) begin
      rdvs = 16'($urandom_range(1, 65535));
      rdvd = {16'($urandom_range(0, int'(rdvs) - 1)), 16'($urandom)};
      full_op($sformatf("rand%0d", i), rdvd, rdvs, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
